// File: rtl/data_producer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_producer_pkg
//  Description : Shared constants and types for the data_producer block:
//                FSM state encoding, mode codes, data width and the
//                Fibonacci word-count ceiling.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_producer_pkg;

    localparam int DATA_W      = 16;
    // F24 = 46368 is the largest Fibonacci number that fits in DATA_W bits
    localparam int FIB_MAX_DEF = 25;
    // Word counter width; must hold FIB_MAX
    localparam int CNT_W       = 5;

    localparam logic MODE_FIB = 1'b0;
    localparam logic MODE_TMR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_GAPW  = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/data_producer_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : data_producer_seq_gen
//  Description : Word-sequence datapath. Produces either the Fibonacci
//                sequence F0, F1, ... for a loaded word count, or a countdown
//                from a loaded seed to 0.
//  Ports       : clk, rst      - clock, async active-high reset
//                load_i        - capture mode/seed/count, value_o = first word
//                advance_i     - step to the next word
//                mode_i        - MODE_FIB or MODE_TMR (used on load_i)
//                seed_i        - countdown start value
//                count_i       - Fibonacci word count (non-zero when used)
//                value_o       - current word
//                last_o        - current word is the final one of the run
//  Revision    : 1.0 - initial release
// ============================================================================
module data_producer_seq_gen
    import data_producer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              advance_i,
    input  logic              mode_i,
    input  logic [DATA_W-1:0] seed_i,
    input  logic [CNT_W-1:0]  count_i,
    output logic [DATA_W-1:0] value_o,
    output logic              last_o
);

    logic              fib_q;
    logic [DATA_W-1:0] cur_q;    // word being offered
    logic [DATA_W-1:0] nxt_q;    // following Fibonacci word
    logic [CNT_W-1:0]  cnt_q;    // Fibonacci words still to deliver, incl. cur_q

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fib_q <= 1'b0;
            cur_q <= '0;
            nxt_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            fib_q <= (mode_i == MODE_FIB);
            if (mode_i == MODE_FIB) begin
                cur_q <= '0;
                nxt_q <= DATA_W'(1);
                cnt_q <= count_i;
            end else begin
                cur_q <= seed_i;
                nxt_q <= '0;
                cnt_q <= '0;
            end
        end else if (advance_i) begin
            if (fib_q) begin
                cur_q <= nxt_q;
                // Wraps only past F24, which is never offered because the
                // count is capped; the wrapped value is never emitted.
                nxt_q <= cur_q + nxt_q;
                cnt_q <= cnt_q - CNT_W'(1);
            end else begin
                // Never advanced at 0 (that word is last), so no wrap.
                cur_q <= cur_q - DATA_W'(1);
            end
        end
    end

    assign value_o = cur_q;
    assign last_o  = fib_q ? (cnt_q == CNT_W'(1)) : (cur_q == '0);

endmodule
`default_nettype wire

// File: rtl/data_producer.sv
`default_nettype none
// ============================================================================
//  Module      : data_producer
//  Description : Write-side word producer for the dual-clock output buffer.
//                Emits a Fibonacci sequence or a countdown on data_1 with a
//                data_1_en valid, stalling while buffer_full is high.
//  Ports       : clk, rst      - producer clock, async active-high reset
//                start, stop   - run request (idle only) / abort
//                mode,prog_val - run configuration, sampled with start
//                buffer_full   - backpressure; word transfers when low
//                data_1_en     - offered word valid
//                data_1        - offered word
//                busy          - run in progress
//                done          - one-cycle pulse on normal completion
//                ovf           - Fibonacci count was clamped (sticky)
//  Revision    : 1.0 - initial release
// ============================================================================
module data_producer
    import data_producer_pkg::*;
#(
    parameter int GAP     = 0,
    parameter int FIB_MAX = FIB_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic [DATA_W-1:0] prog_val,
    input  logic              buffer_full,
    output logic              data_1_en,
    output logic [DATA_W-1:0] data_1,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    // Gap counter holds GAP-1 .. 0
    localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             ovf_q, ovf_d;

    logic             w_load;
    logic             w_adv;
    logic             w_last;
    logic             w_clamp;
    logic             w_fib_empty;
    logic [CNT_W-1:0] w_count;

    assign w_clamp     = (mode == MODE_FIB) && (prog_val > DATA_W'(FIB_MAX));
    assign w_fib_empty = (mode == MODE_FIB) && (prog_val == '0);
    assign w_count     = w_clamp ? CNT_W'(FIB_MAX) : prog_val[CNT_W-1:0];

    data_producer_seq_gen u_seq_gen (
        .clk       (clk),
        .rst       (rst),
        .load_i    (w_load),
        .advance_i (w_adv),
        .mode_i    (mode),
        .seed_i    (prog_val),
        .count_i   (w_count),
        .value_o   (data_1),
        .last_o    (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        ovf_d     = ovf_q;
        w_load    = 1'b0;
        w_adv     = 1'b0;
        data_1_en = (state_q == ST_OFFER);
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_FIN);

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_load  = 1'b1;
                    ovf_d   = w_clamp;
                    state_d = w_fib_empty ? ST_FIN : ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!buffer_full) begin
                    if (w_last) begin
                        // Final word stays on data_1 after the run
                        state_d = ST_FIN;
                    end else begin
                        w_adv = 1'b1;
                        if (GAP == 0) begin
                            state_d = ST_OFFER;
                        end else begin
                            state_d = ST_GAPW;
                            gap_d   = GAP_LOAD;
                        end
                    end
                end
            end
            ST_GAPW: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (gap_q == '0) begin
                    state_d = ST_OFFER;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ovf = ovf_q;

endmodule
`default_nettype wire
